jtag_tap_ctrl: RTL and testbench
================================

# jtag_tap_ctrl

IEEE 1149.1-style TAP controller that sequences the boundary-scan register (BSR) chain built from single-cell boundary-scan instances. It decodes TMS into the 16-state TAP FSM and holds a 4-bit instruction register. It also owns the 1-bit bypass register and the 32-bit IDCODE register. It drives the BSR control lines (capture enable, update enable, shift select, mode) and muxes TDO from the selected register. All logic runs on one clock; the BSR cells are clocked by the same clock and qualified by these enables.

## Interface
Parameters:
- IR_WIDTH, 4, instruction register width.
- IDCODE_VAL, 32'h1000_0001, IDCODE value; bit 0 must be 1.
- OP_EXTEST, 4'b0000, EXTEST opcode.
- OP_SAMPLE, 4'b0001, SAMPLE/PRELOAD opcode.
- OP_IDCODE, 4'b0010, IDCODE opcode.
- OP_BYPASS, 4'b1111, BYPASS opcode; all undefined opcodes also select bypass.

Ports:
- clk, in, 1, TAP clock (TCK); all state changes on the rising edge.
- rst, in, 1, asynchronous active-high reset.
- tms, in, 1, test mode select.
- tdi, in, 1, test data in.
- tdo, out, 1, test data out.
- tdo_en, out, 1, TDO output enable.
- bsr_so, in, 1, serial output of the last BSR cell.
- bsr_si, out, 1, serial input to the first BSR cell; equals tdi.
- capture_en, out, 1, BSR capture enable, active low: 0 loads the cells.
- update_en, out, 1, BSR update enable, active high.
- shift_dr, out, 1, BSR shift select: 1 = load from si, 0 = load from data_in.
- mode, out, 1, BSR mode: 1 = cells drive the update latch onto data_out.
- tap_state, out, 4, current FSM state, for debug.
- ir_out, out, IR_WIDTH, current instruction.

## Operation
- FSM states (encoding 0..15, in this order): TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR.
- State transitions, written as tms=0 / tms=1:
  - TLR: RTI / TLR.
  - RTI: RTI / SEL_DR.
  - SEL_DR: CAP_DR / SEL_IR.
  - CAP_DR: SH_DR / EX1_DR.
  - SH_DR: SH_DR / EX1_DR.
  - EX1_DR: PAU_DR / UPD_DR.
  - PAU_DR: PAU_DR / EX2_DR.
  - EX2_DR: SH_DR / UPD_DR.
  - UPD_DR: RTI / SEL_DR.
  - SEL_IR: CAP_IR / TLR.
  - The IR column mirrors the DR column.
- From any state, tms=1 for 5 consecutive clocks reaches TLR.
- In TLR, ir is loaded with OP_IDCODE every clock.
- Instruction register:
  - Shift register ir_sh.
  - CAP_IR edge loads ir_sh = 4'b0001.
  - SH_IR edge does ir_sh = {tdi, ir_sh[3:1]}.
  - UPD_IR edge does ir = ir_sh.
  - ir changes only in UPD_IR or TLR.
- Selected data register is decoded from ir:
  - EXTEST or SAMPLE: BSR.
  - IDCODE: idreg.
  - Anything else: bypass.
- IDCODE register: CAP_DR edge loads IDCODE_VAL; SH_DR edge shifts right with tdi entering bit 31.
- Bypass register: CAP_DR edge loads 0; SH_DR edge loads tdi.
- BSR controls are combinational from state and ir:
  - shift_dr = 1 in SH_DR, else 0.
  - capture_en = 0 only in CAP_DR or SH_DR with BSR selected; otherwise 1, which holds the cells.
  - update_en = 1 only in UPD_DR with BSR selected.
  - mode = 1 iff ir == OP_EXTEST.
- TDO mux:
  - SH_IR: ir_sh[0].
  - SH_DR: bsr_so, idreg[0] or bypass, per the selected register.
  - Otherwise tdo = 0 and tdo_en = 0.
  - tdo_en = 1 only in SH_IR or SH_DR.

## Timing
- Reset (async assert, sync release) values:
  - state = TLR, ir = OP_IDCODE, ir_sh = 4'b0001, idreg = IDCODE_VAL, bypass = 0.
  - tdo = 0, tdo_en = 0, capture_en = 1, update_en = 0, shift_dr = 0, mode = 0.
- Reset asserted mid-shift abandons the shift; ir does not update.
- The next state is registered, so outputs follow the state one clock after the tms sample.
- Capture happens on the edge leaving CAP_DR/CAP_IR. Each shift bit uses the edge while in the shift state. Update happens on the edge leaving UPD_DR/UPD_IR.
- Pause states hold all shift registers and give no BSR enables.
- An N-cell BSR needs N clocks in SH_DR. The first tdo bit is valid in the first SH_DR cycle, before its shift edge.

## Test plan
- Reset, then 5 clocks with tms=1: state stays TLR (0), ir_out = 4'b0010, and all BSR controls are idle.
- From RTI, tms sequence 0,1,0,0 then 32 shifts (tms=0) with tdi=0: tdo streams IDCODE_VAL LSB-first, starting 1,0,0,0…, and tdo_en = 1 throughout.
- Load IR 4'b1111: the shifted-out ir_sh bits are 1,0,0,0. After UPD_IR, ir_out = 1111. A DR shift of 1,0,1 gives a 1-clock-delayed tdo of 0,1,0,1.
- Load EXTEST: mode = 1 after UPD_IR. In the DR scan, capture_en = 0 for exactly the CAP_DR cycle plus the SH_DR cycles, shift_dr = 1 only in SH_DR, and update_en is a single pulse in UPD_DR.
- Load SAMPLE: mode = 0 and the BSR enables behave as under EXTEST. Enter PAU_DR mid-shift for 3 clocks: tdo_en = 0 and the shifted data resumes intact.
- Assert rst during SH_IR after 2 bits of 4'b0000: state = TLR immediately and ir_out = 0010, not 0000.

Source files
------------

// File: rtl/jtag_tap_if.sv
// TAP pin bundle: JTAG serial pins, BSR control lines and debug taps.
// The master side drives tms/tdi/bsr_so; the TAP controller is the slave.
interface jtag_tap_if #(
    parameter int IR_WIDTH = 4
);
    logic                tms;
    logic                tdi;
    logic                tdo;
    logic                tdo_en;
    logic                bsr_so;
    logic                bsr_si;
    logic                capture_en;
    logic                update_en;
    logic                shift_dr;
    logic                mode;
    logic [3:0]          tap_state;
    logic [IR_WIDTH-1:0] ir_out;

    modport master (
        output tms, tdi, bsr_so,
        input  tdo, tdo_en, bsr_si, capture_en, update_en, shift_dr, mode,
               tap_state, ir_out
    );

    modport slave (
        input  tms, tdi, bsr_so,
        output tdo, tdo_en, bsr_si, capture_en, update_en, shift_dr, mode,
               tap_state, ir_out
    );
endinterface

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1-style TAP controller: 16-state FSM, instruction register,
// bypass and IDCODE registers, BSR control lines and the TDO mux.
module jtag_tap_ctrl #(
    parameter int                  IR_WIDTH   = 4,
    parameter logic [31:0]         IDCODE_VAL = 32'h1000_0001,
    parameter logic [IR_WIDTH-1:0] OP_EXTEST  = 4'b0000,
    parameter logic [IR_WIDTH-1:0] OP_SAMPLE  = 4'b0001,
    parameter logic [IR_WIDTH-1:0] OP_IDCODE  = 4'b0010,
    parameter logic [IR_WIDTH-1:0] OP_BYPASS  = 4'b1111
) (
    input  logic       clk,
    input  logic       rst,
    jtag_tap_if.slave  tap
);

    typedef enum logic [3:0] {
        TLR    = 4'd0,
        RTI    = 4'd1,
        SEL_DR = 4'd2,
        CAP_DR = 4'd3,
        SH_DR  = 4'd4,
        EX1_DR = 4'd5,
        PAU_DR = 4'd6,
        EX2_DR = 4'd7,
        UPD_DR = 4'd8,
        SEL_IR = 4'd9,
        CAP_IR = 4'd10,
        SH_IR  = 4'd11,
        EX1_IR = 4'd12,
        PAU_IR = 4'd13,
        EX2_IR = 4'd14,
        UPD_IR = 4'd15
    } state_t;

    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-1){1'b0}}, 1'b1};

    state_t              state_r;
    state_t              state_s;
    logic [IR_WIDTH-1:0] ir_r;
    logic [IR_WIDTH-1:0] ir_sh_r;
    logic [31:0]         idreg_r;
    logic                bypass_r;
    logic                sel_bsr_s;
    logic                sel_id_s;

    // TAP state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= TLR;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode from tms
    always_comb begin
        state_s = state_r;
        case (state_r)
            TLR:     state_s = tap.tms ? TLR    : RTI;
            RTI:     state_s = tap.tms ? SEL_DR : RTI;
            SEL_DR:  state_s = tap.tms ? SEL_IR : CAP_DR;
            CAP_DR:  state_s = tap.tms ? EX1_DR : SH_DR;
            SH_DR:   state_s = tap.tms ? EX1_DR : SH_DR;
            EX1_DR:  state_s = tap.tms ? UPD_DR : PAU_DR;
            PAU_DR:  state_s = tap.tms ? EX2_DR : PAU_DR;
            EX2_DR:  state_s = tap.tms ? UPD_DR : SH_DR;
            UPD_DR:  state_s = tap.tms ? SEL_DR : RTI;
            SEL_IR:  state_s = tap.tms ? TLR    : CAP_IR;
            CAP_IR:  state_s = tap.tms ? EX1_IR : SH_IR;
            SH_IR:   state_s = tap.tms ? EX1_IR : SH_IR;
            EX1_IR:  state_s = tap.tms ? UPD_IR : PAU_IR;
            PAU_IR:  state_s = tap.tms ? EX2_IR : PAU_IR;
            EX2_IR:  state_s = tap.tms ? UPD_IR : SH_IR;
            UPD_IR:  state_s = tap.tms ? SEL_DR : RTI;
            default: state_s = TLR;
        endcase
    end

    // Instruction shift and update registers; TLR forces IDCODE every clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_r    <= OP_IDCODE;
            ir_sh_r <= IR_CAPTURE;
        end else begin
            case (state_r)
                TLR:     ir_r    <= OP_IDCODE;
                CAP_IR:  ir_sh_r <= IR_CAPTURE;
                SH_IR:   ir_sh_r <= {tap.tdi, ir_sh_r[IR_WIDTH-1:1]};
                UPD_IR:  ir_r    <= ir_sh_r;
                default: ir_r    <= ir_r;
            endcase
        end
    end

    // IDCODE and bypass data registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idreg_r  <= IDCODE_VAL;
            bypass_r <= 1'b0;
        end else begin
            case (state_r)
                CAP_DR: begin
                    idreg_r  <= IDCODE_VAL;
                    bypass_r <= 1'b0;
                end
                SH_DR: begin
                    idreg_r  <= {tap.tdi, idreg_r[31:1]};
                    bypass_r <= tap.tdi;
                end
                default: begin
                    idreg_r  <= idreg_r;
                    bypass_r <= bypass_r;
                end
            endcase
        end
    end

    // Data register select; OP_BYPASS and every undefined opcode fall to bypass
    always_comb begin
        sel_bsr_s = (ir_r == OP_EXTEST) || (ir_r == OP_SAMPLE);
        sel_id_s  = (ir_r == OP_IDCODE);
    end

    // BSR control lines and TDO mux, decoded from registered state and ir
    always_comb begin
        tap.tdo        = 1'b0;
        tap.tdo_en     = 1'b0;
        tap.shift_dr   = 1'b0;
        tap.capture_en = 1'b1;
        tap.update_en  = 1'b0;
        tap.mode       = (ir_r == OP_EXTEST);
        tap.bsr_si     = tap.tdi;
        tap.tap_state  = state_r;
        tap.ir_out     = ir_r;
        case (state_r)
            CAP_DR: begin
                tap.capture_en = ~sel_bsr_s;
            end
            SH_DR: begin
                tap.shift_dr   = 1'b1;
                tap.capture_en = ~sel_bsr_s;
                tap.tdo_en     = 1'b1;
                if (sel_bsr_s) begin
                    tap.tdo = tap.bsr_so;
                end else if (sel_id_s) begin
                    tap.tdo = idreg_r[0];
                end else begin
                    tap.tdo = bypass_r;
                end
            end
            UPD_DR: begin
                tap.update_en = sel_bsr_s;
            end
            SH_IR: begin
                tap.tdo_en = 1'b1;
                tap.tdo    = ir_sh_r[0];
            end
            default: begin
                tap.tdo_en = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Scoreboard bench for jtag_tap_ctrl: the stimulus queues one expectation per
// TCK cycle, a negedge monitor pops it and compares the flagged fields.
module tb_jtag_tap_ctrl;

    localparam logic [3:0] S_TLR = 4'd0, S_RTI = 4'd1, S_SELDR = 4'd2, S_CAPDR = 4'd3;
    localparam logic [3:0] S_SHDR = 4'd4, S_EX1DR = 4'd5, S_PAUDR = 4'd6, S_EX2DR = 4'd7;
    localparam logic [3:0] S_UPDDR = 4'd8, S_SELIR = 4'd9, S_CAPIR = 4'd10, S_SHIR = 4'd11;
    localparam logic [3:0] S_EX1IR = 4'd12, S_UPDIR = 4'd15;
    localparam logic [31:0] IDC = 32'h1000_0001;

    typedef struct packed {
        logic [63:0] tag;
        logic        c_st;
        logic [3:0]  st;
        logic        c_tdo;
        logic        tdo;
        logic        tdo_en;
        logic        c_ctl;
        logic        cap;
        logic        upd;
        logic        sh;
        logic        md;
        logic        si;
        logic        c_ir;
        logic [3:0]  ir;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    exp_t q[$];

    jtag_tap_if #(.IR_WIDTH(4)) tif ();

    jtag_tap_ctrl dut (
        .clk (clk),
        .rst (rst),
        .tap (tif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t e_st(input logic [63:0] tag, input logic [3:0] st);
        exp_t e;
        e      = '0;
        e.tag  = tag;
        e.c_st = 1'b1;
        e.st   = st;
        return e;
    endfunction

    function automatic exp_t e_tdo(input logic [63:0] tag, input logic t, input logic en);
        exp_t e;
        e        = '0;
        e.tag    = tag;
        e.c_tdo  = 1'b1;
        e.tdo    = t;
        e.tdo_en = en;
        return e;
    endfunction

    function automatic exp_t e_ctl(input logic [63:0] tag, input logic [3:0] st,
                                   input logic [3:0] ir, input logic cap, input logic upd,
                                   input logic sh, input logic md);
        exp_t e;
        e       = '0;
        e.tag   = tag;
        e.c_st  = 1'b1;
        e.st    = st;
        e.c_ir  = 1'b1;
        e.ir    = ir;
        e.c_ctl = 1'b1;
        e.cap   = cap;
        e.upd   = upd;
        e.sh    = sh;
        e.md    = md;
        return e;
    endfunction

    function automatic exp_t add_tdo(input exp_t ein, input logic t, input logic en);
        exp_t e;
        e        = ein;
        e.c_tdo  = 1'b1;
        e.tdo    = t;
        e.tdo_en = en;
        return e;
    endfunction

    task automatic check(input logic [63:0] tag, input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s/%s: got %0h expected %0h at %0t", tag, name, act, exp, $time);
        end
    endtask

    // One TCK cycle: drive pins after the edge and queue what this cycle must show
    task automatic step(input logic tms, input logic tdi, input logic so, input exp_t e);
        exp_t ee;
        @(posedge clk);
        #1;
        tif.tms    = tms;
        tif.tdi    = tdi;
        tif.bsr_so = so;
        ee         = e;
        ee.si      = tdi;
        q.push_back(ee);
    endtask

    // Monitor: compare the DUT against the queued expectation for this cycle
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.c_st) check(e.tag, "tap_state", int'(tif.tap_state), int'(e.st));
            if (e.c_ir) check(e.tag, "ir_out", int'(tif.ir_out), int'(e.ir));
            if (e.c_tdo) begin
                check(e.tag, "tdo_en", int'(tif.tdo_en), int'(e.tdo_en));
                check(e.tag, "tdo", int'(tif.tdo), int'(e.tdo));
            end
            if (e.c_ctl) begin
                check(e.tag, "capture_en", int'(tif.capture_en), int'(e.cap));
                check(e.tag, "update_en", int'(tif.update_en), int'(e.upd));
                check(e.tag, "shift_dr", int'(tif.shift_dr), int'(e.sh));
                check(e.tag, "mode", int'(tif.mode), int'(e.md));
                check(e.tag, "bsr_si", int'(tif.bsr_si), int'(e.si));
            end
        end
    end

    // From RTI: load op into IR, checking the captured 1,0,0,0 shift-out; ends in RTI
    task automatic load_ir(input logic [3:0] op);
        logic [3:0] capv;
        capv = 4'b0001;
        step(1'b1, 1'b0, 1'b0, e_st("ld_rti", S_RTI));
        step(1'b1, 1'b0, 1'b0, e_st("ld_seldr", S_SELDR));
        step(1'b0, 1'b0, 1'b0, e_st("ld_selir", S_SELIR));
        step(1'b0, 1'b0, 1'b0, e_st("ld_capir", S_CAPIR));
        for (int i = 0; i < 4; i++) begin
            step((i == 3), op[i], 1'b0, e_tdo("ir_shout", capv[i], 1'b1));
        end
        step(1'b1, 1'b0, 1'b0, e_st("ld_ex1ir", S_EX1IR));
        step(1'b0, 1'b0, 1'b0, e_st("ld_updir", S_UPDIR));
        step(1'b0, 1'b0, 1'b0, e_ctl("ld_done", S_RTI, op, 1'b1, 1'b0, 1'b0, (op == 4'b0000)));
    endtask

    // From RTI: walk to CAP_DR and check its controls; leaves the DUT entering SH_DR
    task automatic enter_dr(input logic [3:0] ir, input logic cap, input logic md);
        step(1'b1, 1'b0, 1'b0, e_st("dr_rti", S_RTI));
        step(1'b0, 1'b0, 1'b0, e_st("dr_seldr", S_SELDR));
        step(1'b0, 1'b0, 1'b0, e_ctl("dr_cap", S_CAPDR, ir, cap, 1'b0, 1'b0, md));
    endtask

    // From EX1_DR: through UPD_DR back to RTI, checking the update pulse
    task automatic leave_dr(input logic [3:0] ir, input logic upd, input logic md);
        step(1'b1, 1'b0, 1'b0, e_ctl("dr_ex1", S_EX1DR, ir, 1'b1, 1'b0, 1'b0, md));
        step(1'b0, 1'b0, 1'b0, e_ctl("dr_upd", S_UPDDR, ir, 1'b1, upd, 1'b0, md));
        step(1'b0, 1'b0, 1'b0, e_ctl("dr_rti2", S_RTI, ir, 1'b1, 1'b0, 1'b0, md));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] idc;
        logic [3:0]  byp_tdi;
        logic [3:0]  byp_tdo;
        logic [2:0]  so_pat;
        idc     = IDC;
        byp_tdi = 4'b0101;
        byp_tdo = 4'b1010;
        so_pat  = 3'b011;
        checks   = 0;
        failures = 0;
        rst        = 1'b1;
        tif.tms    = 1'b1;
        tif.tdi    = 1'b0;
        tif.bsr_so = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state and five TLR clocks with tms=1
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, add_tdo(e_ctl("tlr", S_TLR, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0),
                                           1'b0, 1'b0));
        end
        step(1'b0, 1'b0, 1'b0, e_st("tlr_exit", S_TLR));

        // IDCODE scan: 32 bits LSB-first
        enter_dr(4'b0010, 1'b1, 1'b0);
        for (int i = 0; i < 32; i++) begin
            step((i == 31), 1'b0, 1'b0, e_tdo("idcode", idc[i], 1'b1));
        end
        leave_dr(4'b0010, 1'b0, 1'b0);

        // BYPASS: one-clock delayed echo of tdi
        load_ir(4'b1111);
        enter_dr(4'b1111, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step((i == 3), byp_tdi[i], 1'b0, e_tdo("bypass", byp_tdo[i], 1'b1));
        end
        leave_dr(4'b1111, 1'b0, 1'b0);

        // EXTEST: mode set, BSR enables, tdo follows bsr_so
        load_ir(4'b0000);
        enter_dr(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step((i == 2), 1'b1, so_pat[i],
                 add_tdo(e_ctl("extest_sh", S_SHDR, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1),
                         so_pat[i], 1'b1));
        end
        leave_dr(4'b0000, 1'b1, 1'b1);

        // SAMPLE with a three-clock pause mid-shift
        load_ir(4'b0001);
        enter_dr(4'b0001, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1,
             add_tdo(e_ctl("sample_sh", S_SHDR, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0), 1'b1, 1'b1));
        step(1'b0, 1'b0, 1'b0, e_ctl("sample_ex1", S_EX1DR, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++) begin
            step((i == 2), 1'b0, 1'b1,
                 add_tdo(e_ctl("sample_pau", S_PAUDR, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0),
                         1'b0, 1'b0));
        end
        step(1'b0, 1'b0, 1'b0, e_ctl("sample_ex2", S_EX2DR, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0));
        step(1'b1, 1'b0, 1'b0,
             add_tdo(e_ctl("sample_sh2", S_SHDR, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0), 1'b0, 1'b1));
        leave_dr(4'b0001, 1'b1, 1'b0);

        // Reset during SH_IR after two bits of 0000
        step(1'b1, 1'b0, 1'b0, e_st("rs_rti", S_RTI));
        step(1'b1, 1'b0, 1'b0, e_st("rs_seldr", S_SELDR));
        step(1'b0, 1'b0, 1'b0, e_st("rs_selir", S_SELIR));
        step(1'b0, 1'b0, 1'b0, e_st("rs_capir", S_CAPIR));
        step(1'b0, 1'b0, 1'b0, e_ctl("rs_sh0", S_SHIR, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0));
        step(1'b0, 1'b0, 1'b0, e_st("rs_sh1", S_SHIR));
        @(posedge clk);
        #1;
        rst = 1'b1;
        q.push_back(add_tdo(e_ctl("rst_mid", S_TLR, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0),
                            1'b0, 1'b0));
        @(posedge clk);
        #1;
        rst     = 1'b0;
        tif.tms = 1'b0;
        q.push_back(e_ctl("rst_rel", S_TLR, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0));

        // IDCODE scan paused after two bits, then resumed to the end
        step(1'b0, 1'b0, 1'b0, e_ctl("p_rti", S_RTI, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0));
        enter_dr(4'b0010, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, e_tdo("idp_b0", idc[0], 1'b1));
        step(1'b1, 1'b0, 1'b0, e_tdo("idp_b1", idc[1], 1'b1));
        step(1'b0, 1'b0, 1'b0, e_st("idp_ex1", S_EX1DR));
        for (int i = 0; i < 3; i++) begin
            step((i == 2), 1'b1, 1'b0, add_tdo(e_st("idp_pau", S_PAUDR), 1'b0, 1'b0));
        end
        step(1'b0, 1'b0, 1'b0, e_st("idp_ex2", S_EX2DR));
        for (int i = 2; i < 32; i++) begin
            step((i == 31), 1'b0, 1'b0, e_tdo("idp_res", idc[i], 1'b1));
        end
        leave_dr(4'b0010, 1'b0, 1'b0);

        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
